uart_ram_tft: RTL and testbench

- Receives 16-bit RGB565 pixels over a 115200-baud 8N1 UART, high byte first, and stores them sequentially in an on-chip image RAM.
- Continuously scans a 480x272 parallel-RGB TFT panel from the same 50 MHz clock.
- Shows the RAM image in the top-left IMG_W x IMG_H window; the rest of the active area is black.
- Top-level glue between the UART host link and the LCD connector.

---
 rtl/uart_ram_tft_pkg.sv | 33 +++
 rtl/uart_ram_tft_if.sv | 20 ++
 rtl/uart_byte_rx.sv | 103 ++++++++++
 rtl/uart_ram_tft.sv | 156 +++++++++++++++
 tb/tb_uart_ram_tft.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_ram_tft_pkg.sv
// uart_ram_tft_pkg: shared constants and types for the UART-to-TFT image path.
//   - Default TFT timing (pixel clocks / lines), their totals and the
//     active-area start offsets.
//   - UART bit period in system clocks for the default clock and baud rate.
//   - Receiver state encoding.
package uart_ram_tft_pkg;

    localparam int unsigned CLK_FREQ_DEF = 50_000_000;
    localparam int unsigned BAUD_DEF     = 115_200;
    localparam int unsigned BIT_CNT      = CLK_FREQ_DEF / BAUD_DEF;   // 434

    localparam int unsigned H_SYNC_DEF  = 41;
    localparam int unsigned H_BACK_DEF  = 2;
    localparam int unsigned H_ACT_DEF   = 480;
    localparam int unsigned H_FRONT_DEF = 2;
    localparam int unsigned H_TOTAL     = H_SYNC_DEF + H_BACK_DEF + H_ACT_DEF + H_FRONT_DEF; // 525
    localparam int unsigned H_START     = H_SYNC_DEF + H_BACK_DEF;                         // 43

    localparam int unsigned V_SYNC_DEF  = 10;
    localparam int unsigned V_BACK_DEF  = 2;
    localparam int unsigned V_ACT_DEF   = 272;
    localparam int unsigned V_FRONT_DEF = 2;
    localparam int unsigned V_TOTAL     = V_SYNC_DEF + V_BACK_DEF + V_ACT_DEF + V_FRONT_DEF; // 286
    localparam int unsigned V_START     = V_SYNC_DEF + V_BACK_DEF;                         // 12

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_ram_tft_if.sv
// uart_ram_tft_if: byte link from the UART receiver to the pixel assembler.
//   data[7:0]  received byte, valid while rx_done is high
//   rx_done    one-clock strobe per correctly framed byte
//   busy       receiver is inside a frame (only with RX_PAIR_TIMEOUT_EN)
// Modports: master = receiver side, slave = consumer side.
interface uart_ram_tft_if;

    logic [7:0] data;
    logic       rx_done;
`ifdef RX_PAIR_TIMEOUT_EN
    logic       busy;

    modport master (output data, output rx_done, output busy);
    modport slave  (input  data, input  rx_done, input  busy);
`else
    modport master (output data, output rx_done);
    modport slave  (input  data, input  rx_done);
`endif

endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver.
//   clk, rst_n  system clock, asynchronous active-low reset
//   rx          serial input (idles high), 2-FF synchronised internally
//   link        master side of uart_ram_tft_if: data + rx_done strobe
// Start bit is re-checked at half a bit period (glitch rejection); data bits
// are sampled LSB first at bit centre; a low stop bit drops the byte.
// With RX_PAIR_TIMEOUT_EN defined, link.busy flags an in-progress frame.
module uart_byte_rx
    import uart_ram_tft_pkg::*;
#(
    parameter int unsigned BIT_CLKS = BIT_CNT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx,
    uart_ram_tft_if.master link
);

    localparam int unsigned   CW        = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);

    logic            rx_meta, rx_sync, rx_prev, fall;
    rx_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_n;
    logic [7:0]      shift, shift_n, data_q, data_n;
    logic            done_q, done_n;

    assign fall = rx_prev & ~rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            data_q  <= data_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        shift_n = shift;
        data_n  = data_q;
        done_n  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (fall) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_sync, shift[7:1]};
                    bit_n   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    if (rx_sync) begin
                        done_n = 1'b1;
                        data_n = shift;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign link.data    = data_q;
    assign link.rx_done = done_q;
`ifdef RX_PAIR_TIMEOUT_EN
    assign link.busy    = (state != RX_IDLE);
`endif

endmodule

// File: rtl/uart_ram_tft.sv
// uart_ram_tft: UART-loaded RGB565 image buffer scanned out to a parallel TFT.
//   Clk, Reset_n       50 MHz system clock, asynchronous active-low reset
//   uart_rx            8N1 serial input, pixels sent high byte first
//   TFT_RGB/HS/VS/DE   panel data, active-low syncs, data enable
//   TFT_CLK            pixel clock = Clk/4
//   TFT_BL             backlight enable
//   hcount_r/vcount_r  raster counters
// Optional macro RX_PAIR_TIMEOUT_EN: a latched high byte is dropped after
// 16 idle bit periods without a low byte.
module uart_ram_tft #(
    parameter int unsigned CLK_FREQ = uart_ram_tft_pkg::CLK_FREQ_DEF,
    parameter int unsigned BAUD     = uart_ram_tft_pkg::BAUD_DEF,
    parameter int unsigned IMG_W    = 128,
    parameter int unsigned IMG_H    = 128,
    parameter int unsigned H_SYNC   = uart_ram_tft_pkg::H_SYNC_DEF,
    parameter int unsigned H_BACK   = uart_ram_tft_pkg::H_BACK_DEF,
    parameter int unsigned H_ACT    = uart_ram_tft_pkg::H_ACT_DEF,
    parameter int unsigned H_FRONT  = uart_ram_tft_pkg::H_FRONT_DEF,
    parameter int unsigned V_SYNC   = uart_ram_tft_pkg::V_SYNC_DEF,
    parameter int unsigned V_BACK   = uart_ram_tft_pkg::V_BACK_DEF,
    parameter int unsigned V_ACT    = uart_ram_tft_pkg::V_ACT_DEF,
    parameter int unsigned V_FRONT  = uart_ram_tft_pkg::V_FRONT_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        uart_rx,
    output logic [15:0] TFT_RGB,
    output logic        TFT_HS,
    output logic        TFT_VS,
    output logic        TFT_DE,
    output logic        TFT_CLK,
    output logic        TFT_BL,
    output logic [11:0] hcount_r,
    output logic [11:0] vcount_r
);

    localparam int unsigned BIT_CLKS = CLK_FREQ / BAUD;
    localparam int unsigned DEPTH    = IMG_W * IMG_H;
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned H_PERIOD = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int unsigned V_PERIOD = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam int unsigned H_BEG    = H_SYNC + H_BACK;
    localparam int unsigned V_BEG    = V_SYNC + V_BACK;

    uart_ram_tft_if link ();

    uart_byte_rx #(.BIT_CLKS(BIT_CLKS)) u_rx (
        .clk   (Clk),
        .rst_n (Reset_n),
        .rx    (uart_rx),
        .link  (link)
    );

    // ---------------- pixel assembly ----------------
    logic          hi_valid;
    logic [7:0]    hi_byte;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          pair_timeout;

    assign wr_en = link.rx_done & hi_valid;

`ifdef RX_PAIR_TIMEOUT_EN
    localparam int unsigned TO_CLKS = 16 * BIT_CLKS;
    localparam int unsigned TW      = $clog2(TO_CLKS + 1);
    logic [TW-1:0] to_cnt;

    // Only idle-line time counts toward the timeout.
    assign pair_timeout = hi_valid & ~link.busy & (to_cnt == TW'(TO_CLKS - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                                 to_cnt <= '0;
        else if (!hi_valid || link.rx_done || link.busy) to_cnt <= '0;
        else                                          to_cnt <= to_cnt + 1'b1;
    end
`else
    assign pair_timeout = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hi_valid <= 1'b0;
            hi_byte  <= '0;
            wr_addr  <= '0;
        end else if (link.rx_done) begin
            hi_valid <= ~hi_valid;
            if (!hi_valid) hi_byte <= link.data;
            else           wr_addr <= (wr_addr == AW'(DEPTH - 1)) ? '0 : wr_addr + 1'b1;
        end else if (pair_timeout) begin
            hi_valid <= 1'b0;
        end
    end

    // ---------------- image RAM ----------------
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;

    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_addr] <= {hi_byte, link.data};
        rd_data <= mem[rd_addr];
    end

    // ---------------- raster timing ----------------
    // Counters step at div==1 (TFT_CLK rising); RAM data returns at div==3,
    // where all panel outputs are registered together on TFT_CLK falling so
    // they are stable across the next rising edge.
    logic [1:0]  div;
    logic        tick, out_en;
    logic [11:0] x_off, y_off;
    logic        de_c, in_img;

    assign tick    = (div == 2'd1);
    assign out_en  = (div == 2'd3);
    assign TFT_CLK = div[1];

    always_comb begin
        x_off  = hcount_r - 12'(H_BEG);
        y_off  = vcount_r - 12'(V_BEG);
        de_c   = (hcount_r >= 12'(H_BEG)) && (hcount_r < 12'(H_BEG + H_ACT)) &&
                 (vcount_r >= 12'(V_BEG)) && (vcount_r < 12'(V_BEG + V_ACT));
        in_img = de_c && (x_off < 12'(IMG_W)) && (y_off < 12'(IMG_H));
        rd_addr = AW'({12'd0, y_off} * 24'(IMG_W) + {12'd0, x_off});
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div      <= '0;
            hcount_r <= '0;
            vcount_r <= '0;
            TFT_BL   <= 1'b0;
            TFT_RGB  <= '0;
            TFT_HS   <= 1'b1;
            TFT_VS   <= 1'b1;
            TFT_DE   <= 1'b0;
        end else begin
            div    <= div + 2'd1;
            TFT_BL <= 1'b1;
            if (tick) begin
                if (hcount_r == 12'(H_PERIOD - 1)) begin
                    hcount_r <= '0;
                    vcount_r <= (vcount_r == 12'(V_PERIOD - 1)) ? '0 : vcount_r + 12'd1;
                end else begin
                    hcount_r <= hcount_r + 12'd1;
                end
            end
            if (out_en) begin
                TFT_HS  <= (hcount_r >= 12'(H_SYNC));
                TFT_VS  <= (vcount_r >= 12'(V_SYNC));
                TFT_DE  <= de_c;
                TFT_RGB <= in_img ? rd_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_ram_tft.sv
// tb_uart_ram_tft: self-checking bench for uart_ram_tft with a reduced
// raster, image size and bit period. Received bytes are scoreboarded through
// a probe receiver on the same line; whole frames are compared against a
// bench-side image model.
module tb_uart_ram_tft;

    localparam int unsigned CLK_HALF = 10;
    localparam int unsigned BIT_CLKS = 16;
    localparam int unsigned BIT_T    = BIT_CLKS * 2 * CLK_HALF;
    localparam int unsigned IMG_W    = 16;
    localparam int unsigned IMG_H    = 4;
    localparam int unsigned DEPTH    = IMG_W * IMG_H;
    localparam int unsigned T_HSYNC  = 5;
    localparam int unsigned T_HBACK  = 3;
    localparam int unsigned T_HACT   = 24;
    localparam int unsigned T_HFRONT = 4;
    localparam int unsigned T_VSYNC  = 2;
    localparam int unsigned T_VBACK  = 2;
    localparam int unsigned T_VACT   = 8;
    localparam int unsigned T_VFRONT = 2;
    localparam int unsigned H_TOT    = T_HSYNC + T_HBACK + T_HACT + T_HFRONT;
    localparam int unsigned V_TOT    = T_VSYNC + T_VBACK + T_VACT + T_VFRONT;
    localparam int unsigned H_BEG    = T_HSYNC + T_HBACK;
    localparam int unsigned V_BEG    = T_VSYNC + T_VBACK;
    localparam int unsigned FRAME    = H_TOT * V_TOT;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [15:0] TFT_RGB;
    logic        TFT_HS, TFT_VS, TFT_DE, TFT_CLK, TFT_BL;
    logic [11:0] hcount_r, vcount_r;

    always #(CLK_HALF) Clk = ~Clk;

    uart_ram_tft #(
        .CLK_FREQ (50_000_000),
        .BAUD     (50_000_000 / BIT_CLKS),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .H_SYNC   (T_HSYNC),
        .H_BACK   (T_HBACK),
        .H_ACT    (T_HACT),
        .H_FRONT  (T_HFRONT),
        .V_SYNC   (T_VSYNC),
        .V_BACK   (T_VBACK),
        .V_ACT    (T_VACT),
        .V_FRONT  (T_VFRONT)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .uart_rx  (uart_rx),
        .TFT_RGB  (TFT_RGB),
        .TFT_HS   (TFT_HS),
        .TFT_VS   (TFT_VS),
        .TFT_DE   (TFT_DE),
        .TFT_CLK  (TFT_CLK),
        .TFT_BL   (TFT_BL),
        .hcount_r (hcount_r),
        .vcount_r (vcount_r)
    );

    uart_ram_tft_if rx_link ();

    uart_byte_rx #(.BIT_CLKS(BIT_CLKS)) u_rx_probe (
        .clk   (Clk),
        .rst_n (Reset_n),
        .rx    (uart_rx),
        .link  (rx_link)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  exp_q [$];
    logic [15:0] img   [DEPTH];
    bit          known [DEPTH];
    int unsigned wptr = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte scoreboard: every correctly framed byte must come out in order.
    always @(negedge Clk) begin
        if (Reset_n && rx_link.rx_done === 1'b1) begin
            if (exp_q.size() == 0) check("rx_extra_byte", 64'(rx_link.rx_done), 64'd0);
            else                   check("rx_byte", 64'(rx_link.data), 64'(exp_q.pop_front()));
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) exp_q.push_back(b);
        uart_rx = 1'b0;
        #(BIT_T);
        for (int unsigned i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #(BIT_T);
        end
        uart_rx = stop_ok;
        #(BIT_T);
        uart_rx = 1'b1;
        #(BIT_T);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
        img[wptr]   = w;
        known[wptr] = 1'b1;
        wptr        = (wptr + 1) % DEPTH;
    endtask

    task automatic sample_tick();
        @(negedge TFT_CLK);
        @(negedge Clk);
    endtask

    task automatic scan_frame(input string tag);
        int unsigned guard, hs_lo, vs_lo, de_hi;
        guard = 0; hs_lo = 0; vs_lo = 0; de_hi = 0;
        sample_tick();
        while (!(hcount_r == 12'd0 && vcount_r == 12'd0) && guard < 2 * FRAME) begin
            sample_tick();
            guard++;
        end
        check({tag, "_sync"}, 64'({vcount_r, hcount_r}), 64'd0);
        for (int unsigned t = 0; t < FRAME; t++) begin
            int unsigned eh, ev, a;
            logic        e_de, e_hs, e_vs, e_in;
            logic [15:0] e_rgb, o_rgb;
            eh    = t % H_TOT;
            ev    = t / H_TOT;
            e_hs  = (eh >= T_HSYNC);
            e_vs  = (ev >= T_VSYNC);
            e_de  = (eh >= H_BEG) && (eh < H_BEG + T_HACT) && (ev >= V_BEG) && (ev < V_BEG + T_VACT);
            e_in  = e_de && (eh - H_BEG < IMG_W) && (ev - V_BEG < IMG_H);
            a     = e_in ? (ev - V_BEG) * IMG_W + (eh - H_BEG) : 0;
            e_rgb = e_in ? img[a] : 16'h0;
            o_rgb = TFT_RGB;
            // RAM locations never written hold no defined value.
            if (e_in && !known[a]) begin
                e_rgb = 16'h0;
                o_rgb = 16'h0;
            end
            if (!TFT_HS) hs_lo++;
            if (!TFT_VS) vs_lo++;
            if (TFT_DE)  de_hi++;
            check(tag, 64'({vcount_r, hcount_r, TFT_DE, TFT_HS, TFT_VS, o_rgb}),
                       64'({12'(ev), 12'(eh), e_de, e_hs, e_vs, e_rgb}));
            if (t != FRAME - 1) sample_tick();
        end
        check({tag, "_hs_low_ticks"}, 64'(hs_lo), 64'(T_HSYNC * V_TOT));
        check({tag, "_vs_low_ticks"}, 64'(vs_lo), 64'(T_VSYNC * H_TOT));
        check({tag, "_de_high_ticks"}, 64'(de_hi), 64'(T_HACT * T_VACT));
    endtask

    initial begin
        #(1_600_000);
        $display("FAIL watchdog: time limit reached with checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) known[i] = 1'b0;

        // Reset state
        #(100);
        check("reset_outputs",
              64'({TFT_RGB, TFT_HS, TFT_VS, TFT_DE, TFT_CLK, TFT_BL, hcount_r, vcount_r}),
              64'({16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0}));
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (k == 0) check("backlight", 64'(TFT_BL), 64'd1);
            check("tft_clk", 64'(TFT_CLK), 64'(((k + 1) >> 1) & 1));
        end

        // 16 sequential words, then one frame of scan-out
        for (int unsigned i = 0; i < 16; i++) send_word(16'(i));
        scan_frame("frame_seq");

        // Framing error must not disturb byte pairing
        send_byte(8'h55, 1'b0);
        send_word(16'hABCD);
        scan_frame("frame_badstop");

        // Reset with a high byte latched and a byte half received
        send_byte(8'h77, 1'b1);
        uart_rx = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge Clk);
        Reset_n = 1'b0;
        uart_rx = 1'b1;
        @(negedge Clk);
        check("midreset_state", 64'({hcount_r, vcount_r, TFT_DE, TFT_BL, TFT_CLK}), 64'd0);
        repeat (4) @(negedge Clk);
        Reset_n = 1'b1;
        wptr = 0;

        // DEPTH+1 words: the last one wraps onto address 0
        for (int unsigned i = 0; i <= DEPTH; i++) send_word(16'h1000 + 16'(i));
        scan_frame("frame_wrap");

        check("rx_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
